// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared types and constants for the core-side UART port
//
// Purpose: FSM state encoding shared by the TX and RX engines, frame width and
//          the default baud divider (100 MHz / 115200).
// Ports:   none (package).
package io_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS      = 8;
  localparam int CLK_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/io_byte_fifo.sv
// rtl/io_byte_fifo.sv - synchronous byte FIFO with show-ahead head output
//
// Purpose: 2^AW-entry byte buffer. head_o always shows the oldest entry.
//          A push while full is accepted only when a pop happens on the same edge.
// Ports:   clk, rstn    clock, synchronous active-low reset
//          push_i       write data_i this edge
//          data_i[7:0]  write data
//          pop_i        discard the head entry this edge
//          head_o[7:0]  oldest entry (undefined content while empty)
//          full_o       all entries occupied
//          empty_o      no entries
module io_byte_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0]  mem_q [0:(1<<AW)-1];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/io_uart_port.sv
// rtl/io_uart_port.sv - core byte I/O handshake to 8N1 UART TX/RX bridge
//
// Purpose: OUT bytes are buffered in a TX FIFO and serialized on uart_txd.
//          RX frames are deserialized and offered to the core IN request.
//          Macro IO_UART_RX_FIFO_EN: RX buffer is a 2^FIFO_AW FIFO; otherwise
//          a single holding register.
// Ports:   clk, rstn                      clock, synchronous active-low reset
//          core_out_data/vld/rdy          OUT byte handshake (block is sink)
//          core_in_data/vld/rdy           IN byte handshake (block is source)
//          uart_rxd, uart_txd             serial pins (txd idles high)
//          rx_overrun, rx_frame_err       sticky error flags, cleared by reset
module io_uart_port
  import io_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] core_out_data,
  input  logic       core_out_vld,
  output logic       core_out_rdy,
  output logic [7:0] core_in_data,
  output logic       core_in_vld,
  input  logic       core_in_rdy,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int             BW        = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0]  BAUD_HALF = BW'(CLK_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

  // ---------------- TX ----------------
  uart_state_t   tx_state_q;
  logic [BW-1:0] tx_baud_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shreg_q;
  logic          tx_txd_q;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign core_out_rdy = !tx_full;
  assign tx_push      = core_out_vld && !tx_full;
  // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
  assign tx_pop       = !tx_empty &&
                        ((tx_state_q == IDLE) ||
                         (tx_state_q == STOP && tx_baud_q == BAUD_LAST));
  assign uart_txd     = tx_txd_q;

  io_byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (tx_push),
    .data_i  (core_out_data),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q <= IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_txd_q   <= 1'b1;
    end else begin
      // Line level is registered from the state, so it trails the state by one
      // cycle uniformly; every bit still lasts exactly CLK_PER_BIT cycles.
      case (tx_state_q)
        START:   tx_txd_q <= 1'b0;
        DATA:    tx_txd_q <= tx_shreg_q[0];
        default: tx_txd_q <= 1'b1;
      endcase
      case (tx_state_q)
        IDLE: begin
          if (tx_pop) begin
            tx_shreg_q <= tx_head;
            tx_baud_q  <= '0;
            tx_state_q <= START;
          end
        end
        START: begin
          if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= DATA;
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        DATA: begin
          if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q  <= '0;
            tx_shreg_q <= {1'b0, tx_shreg_q[7:1]};
            if (tx_bit_q == LAST_BIT) tx_state_q <= STOP;
            else                      tx_bit_q   <= tx_bit_q + 1'b1;
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        STOP: begin
          if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q <= '0;
            if (tx_pop) begin
              tx_shreg_q <= tx_head;
              tx_state_q <= START;
            end else begin
              tx_state_q <= IDLE;
            end
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  uart_state_t   rx_state_q;
  logic [BW-1:0] rx_baud_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shreg_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          rx_overrun_q, rx_frame_err_q;
  logic          rx_stop_smp, rx_push, rx_pop, rx_wr;
  logic          rx_full, rx_empty;
  logic [7:0]    rx_head;

  assign rx_stop_smp = (rx_state_q == STOP) && (rx_baud_q == BAUD_LAST);
  assign rx_push     = rx_stop_smp && rx_s2_q;
  assign rx_pop      = core_in_vld && core_in_rdy;
  // A full buffer still takes the byte when the core frees a slot on the same edge.
  assign rx_wr       = rx_push && (!rx_full || rx_pop);

  assign core_in_vld  = !rx_empty;
  assign core_in_data = rx_empty ? 8'h00 : rx_head;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1_q        <= 1'b1;
      rx_s2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_state_q     <= IDLE;
      rx_baud_q      <= '0;
      rx_bit_q       <= '0;
      rx_shreg_q     <= '0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (rx_push && rx_full && !rx_pop) rx_overrun_q   <= 1'b1;
      if (rx_stop_smp && !rx_s2_q)       rx_frame_err_q <= 1'b1;
      case (rx_state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_baud_q  <= '0;
            rx_state_q <= START;
          end
        end
        START: begin
          // Mid-bit recheck; a high line here was a glitch, not a start bit.
          if (rx_baud_q == BAUD_HALF) begin
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? IDLE : DATA;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        DATA: begin
          if (rx_baud_q == BAUD_LAST) begin
            rx_baud_q  <= '0;
            rx_shreg_q <= {rx_s2_q, rx_shreg_q[7:1]};
            if (rx_bit_q == LAST_BIT) rx_state_q <= STOP;
            else                      rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        STOP: begin
          if (rx_baud_q == BAUD_LAST) begin
            rx_baud_q  <= '0;
            rx_state_q <= IDLE;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  end

`ifdef IO_UART_RX_FIFO_EN
  io_byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (rx_wr),
    .data_i  (rx_shreg_q),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );
`else
  logic [7:0] rx_hold_q;
  logic       rx_hold_vld_q;

  assign rx_head  = rx_hold_q;
  assign rx_full  = rx_hold_vld_q;
  assign rx_empty = !rx_hold_vld_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_hold_q     <= '0;
      rx_hold_vld_q <= 1'b0;
    end else if (rx_wr) begin
      rx_hold_q     <= rx_shreg_q;
      rx_hold_vld_q <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_vld_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_io_uart_port.sv
// tb/tb_io_uart_port.sv - directed self-checking bench for io_uart_port
module tb_io_uart_port;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic       clk;
  logic       rstn;
  logic [7:0] core_out_data;
  logic       core_out_vld;
  logic       core_out_rdy;
  logic [7:0] core_in_data;
  logic       core_in_vld;
  logic       core_in_rdy;
  logic       uart_rxd;
  logic       uart_txd;
  logic       rx_overrun;
  logic       rx_frame_err;

  int checks = 0;
  int errors = 0;

  logic       trace [0:511];
  int         accept_cyc [0:7];
  logic       rdy_after [0:7];
  logic [7:0] tx_bytes [0:7];

  io_uart_port #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .core_out_data (core_out_data),
    .core_out_vld  (core_out_vld),
    .core_out_rdy  (core_out_rdy),
    .core_in_data  (core_in_data),
    .core_in_vld   (core_in_vld),
    .core_in_rdy   (core_in_rdy),
    .uart_rxd      (uart_rxd),
    .uart_txd      (uart_txd),
    .rx_overrun    (rx_overrun),
    .rx_frame_err  (rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Offer tx_bytes[0..n-1] with vld held until each accept; trace txd every cycle.
  task automatic run_tx(input int n, input int cycles, output int n_acc);
    int  idx;
    logic acc;
    idx = 0;
    core_out_data = tx_bytes[0];
    core_out_vld  = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      acc = core_out_vld && core_out_rdy;
      tick();
      trace[c] = uart_txd;
      if (acc) begin
        accept_cyc[idx] = c;
        rdy_after[idx]  = core_out_rdy;
        idx++;
        if (idx < n) core_out_data = tx_bytes[idx];
        else begin
          core_out_vld  = 1'b0;
          core_out_data = 8'h00;
        end
      end
    end
    n_acc = idx;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) tick();
    for (int b = 0; b < 8; b++) begin
      uart_rxd = d[b];
      repeat (CPB) tick();
    end
    uart_rxd = stop_bit;
    repeat (CPB) tick();
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; core_out_vld = 1'b0; core_out_data = 8'h00;
    core_in_rdy = 1'b0; uart_rxd = 1'b1;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL rst_txd got %b want 1", uart_txd); end
    checks++; if (core_out_rdy !== 1'b1) begin errors++; $display("FAIL rst_out_rdy got %b want 1", core_out_rdy); end
    checks++; if (core_in_vld !== 1'b0) begin errors++; $display("FAIL rst_in_vld got %b want 0", core_in_vld); end
    checks++; if (core_in_data !== 8'h00) begin errors++; $display("FAIL rst_in_data got %h want 00", core_in_data); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", rx_overrun); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b want 0", rx_frame_err); end
  endtask

  task automatic test_tx_single();
    logic [9:0] exp_bits;
    int n_acc;
    exp_bits = 10'b1101001010;  // A5 framed, first bit in bit 0
    tx_bytes[0] = 8'hA5;
    run_tx(1, 52, n_acc);
    checks++; if (n_acc !== 1) begin errors++; $display("FAIL tx1_accepts got %0d want 1", n_acc); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (trace[i] !== 1'b1) begin errors++; $display("FAIL tx1_pre cyc %0d got %b want 1", i, trace[i]); end
    end
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < CPB; k++) begin
        checks++;
        if (trace[2 + b*CPB + k] !== exp_bits[b]) begin
          errors++; $display("FAIL tx1_bit %0d.%0d got %b want %b", b, k, trace[2 + b*CPB + k], exp_bits[b]);
        end
      end
    end
    for (int i = 42; i < 52; i++) begin
      checks++; if (trace[i] !== 1'b1) begin errors++; $display("FAIL tx1_idle cyc %0d got %b want 1", i, trace[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int  n_acc;
    int  bad;
    logic e;
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h82; tx_bytes[2] = 8'h3C;
    tx_bytes[3] = 8'hF0; tx_bytes[4] = 8'h5A;
    run_tx(5, 212, n_acc);
    checks++; if (n_acc !== 5) begin errors++; $display("FAIL b2b_accepts got %0d want 5", n_acc); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (accept_cyc[i] !== i) begin errors++; $display("FAIL b2b_accept_cyc %0d got %0d want %0d", i, accept_cyc[i], i); end
    end
    checks++; if (rdy_after[3] !== 1'b1) begin errors++; $display("FAIL b2b_rdy_after4 got %b want 1", rdy_after[3]); end
    checks++; if (rdy_after[4] !== 1'b0) begin errors++; $display("FAIL b2b_rdy_full got %b want 0", rdy_after[4]); end
    for (int f = 0; f < 5; f++) begin
      bad = 0;
      for (int b = 0; b < 10; b++) begin
        e = frame_bit(tx_bytes[f], b);
        for (int k = 0; k < CPB; k++)
          if (trace[2 + f*40 + b*CPB + k] !== e) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame %0d got %0d bad samples want 0", f, bad); end
    end
    for (int i = 202; i < 212; i++) begin
      checks++; if (trace[i] !== 1'b1) begin errors++; $display("FAIL b2b_idle cyc %0d got %b want 1", i, trace[i]); end
    end
  endtask

  task automatic test_rx_single();
    core_in_rdy = 1'b1;
    rx_send(8'h3C, 1'b1);
    checks++; if (core_in_vld !== 1'b0) begin errors++; $display("FAIL rx1_early_vld got %b want 0", core_in_vld); end
    tick();
    checks++; if (core_in_vld !== 1'b1) begin errors++; $display("FAIL rx1_vld got %b want 1", core_in_vld); end
    checks++; if (core_in_data !== 8'h3C) begin errors++; $display("FAIL rx1_data got %h want 3c", core_in_data); end
    tick();
    checks++; if (core_in_vld !== 1'b0) begin errors++; $display("FAIL rx1_vld_drop got %b want 0", core_in_vld); end
    checks++; if (core_in_data !== 8'h00) begin errors++; $display("FAIL rx1_data_zero got %h want 00", core_in_data); end
    core_in_rdy = 1'b0;
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rx1_overrun got %b want 0", rx_overrun); end
  endtask

  task automatic test_glitch();
    uart_rxd = 1'b0;
    tick();
    uart_rxd = 1'b1;
    repeat (20) tick();
    checks++; if (core_in_vld !== 1'b0) begin errors++; $display("FAIL glitch_vld got %b want 0", core_in_vld); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err got %b want 0", rx_frame_err); end
    rx_send(8'h96, 1'b1);
    tick();
    checks++; if (core_in_data !== 8'h96) begin errors++; $display("FAIL glitch_next_data got %h want 96", core_in_data); end
    core_in_rdy = 1'b1;
    tick();
    core_in_rdy = 1'b0;
    checks++; if (core_in_vld !== 1'b0) begin errors++; $display("FAIL glitch_pop_vld got %b want 0", core_in_vld); end
  endtask

`ifdef IO_UART_RX_FIFO_EN
  task automatic test_overrun();
    logic [7:0] exp_d [0:3];
    exp_d[0] = 8'hC1; exp_d[1] = 8'h2D; exp_d[2] = 8'h7E; exp_d[3] = 8'h80;
    core_in_rdy = 1'b0;
    for (int i = 0; i < 4; i++) rx_send(exp_d[i], 1'b1);
    tick();
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_after4 got %b want 0", rx_overrun); end
    rx_send(8'hE5, 1'b1);
    tick();
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_after5 got %b want 1", rx_overrun); end
    core_in_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (core_in_vld !== 1'b1) begin errors++; $display("FAIL ovr_drain_vld %0d got %b want 1", i, core_in_vld); end
      checks++; if (core_in_data !== exp_d[i]) begin errors++; $display("FAIL ovr_drain_data %0d got %h want %h", i, core_in_data, exp_d[i]); end
      tick();
    end
    core_in_rdy = 1'b0;
    checks++; if (core_in_vld !== 1'b0) begin errors++; $display("FAIL ovr_drained_vld got %b want 0", core_in_vld); end
  endtask
`else
  task automatic test_overrun();
    core_in_rdy = 1'b0;
    rx_send(8'hD1, 1'b1);
    rx_send(8'h4B, 1'b1);
    tick();
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_hold got %b want 1", rx_overrun); end
    checks++; if (core_in_vld !== 1'b1) begin errors++; $display("FAIL ovr_hold_vld got %b want 1", core_in_vld); end
    checks++; if (core_in_data !== 8'hD1) begin errors++; $display("FAIL ovr_hold_data got %h want d1", core_in_data); end
    core_in_rdy = 1'b1;
    tick();
    core_in_rdy = 1'b0;
    checks++; if (core_in_vld !== 1'b0) begin errors++; $display("FAIL ovr_hold_drained got %b want 0", core_in_vld); end
  endtask
`endif

  task automatic test_frame_err();
    rx_send(8'h5A, 1'b0);
    repeat (4) tick();
    checks++; if (core_in_vld !== 1'b0) begin errors++; $display("FAIL ferr_vld got %b want 0", core_in_vld); end
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", rx_frame_err); end
  endtask

  task automatic test_reset_mid_tx();
    int n_acc;
    int bad;
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00;
    run_tx(3, 12, n_acc);
    checks++; if (trace[2] !== 1'b0) begin errors++; $display("FAIL rmt_started got %b want 0", trace[2]); end
    rstn = 1'b0;
    tick();
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL rmt_txd got %b want 1", uart_txd); end
    checks++; if (core_out_rdy !== 1'b1) begin errors++; $display("FAIL rmt_rdy got %b want 1", core_out_rdy); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rmt_overrun got %b want 0", rx_overrun); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL rmt_frame_err got %b want 0", rx_frame_err); end
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (uart_txd !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmt_flushed got %0d low samples want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_single();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
